wordle_guess_scorer: RTL

//  Consumer end of the on-screen keyboard: accepts committed letters, delete and enter pulses, and builds

---
 rtl/wordle_guess_scorer_pkg.sv | 29 ++
 rtl/wordle_guess_scorer_if.sv | 24 ++
 rtl/wordle_guess_scorer_score_unit.sv | 60 ++++++
 rtl/wordle_guess_scorer.sv | 114 +++++++++++
 4 files changed

// File: rtl/wordle_guess_scorer_pkg.sv
// Shared types and constants for the wordle guess scorer: one-hot states,
// score codes and word geometry.
package wordle_pkg;
    localparam int NUM_ROWS = 6;
    localparam int WORD_LEN = 5;
    localparam int LETTER_W = 5;

    localparam logic [3:0] QI     = 4'b0001;
    localparam logic [3:0] QENTRY = 4'b0010;
    localparam logic [3:0] QSCORE = 4'b0100;
    localparam logic [3:0] QDONE  = 4'b1000;

    localparam logic [1:0] SCORE_NONE   = 2'b00;
    localparam logic [1:0] SCORE_GRAY   = 2'b01;
    localparam logic [1:0] SCORE_YELLOW = 2'b10;
    localparam logic [1:0] SCORE_GREEN  = 2'b11;

    localparam logic [LETTER_W-1:0] LETTER_MAX = 5'd25;

    typedef logic [LETTER_W-1:0]         letter_t;
    typedef letter_t [WORD_LEN-1:0]      word_t;
    typedef logic [WORD_LEN-1:0][1:0]    scores_t;

    function automatic logic all_green(input scores_t s);
        for (int i = 0; i < WORD_LEN; i++)
            if (s[i] != SCORE_GREEN) return 1'b0;
        return 1'b1;
    endfunction
endpackage

// File: rtl/wordle_guess_scorer_if.sv
// Keyboard / renderer side of the guess scorer. The scorer is the slave;
// the keyboard FSM and grid renderer together form the master.
interface wordle_guess_scorer_if;
    import wordle_pkg::*;
    logic    Start, Ack;
    word_t   target;
    letter_t letter_idx;
    logic    letter_vld, del, enter;
    logic [2:0] rd_row, rd_col;
    letter_t rd_letter;
    logic [1:0] rd_score;
    logic [2:0] row_curr, col_curr;
    logic    q_I, q_Entry, q_Score, q_Done;
    logic    done, win;

    modport slave (
        input  Start, Ack, target, letter_idx, letter_vld, del, enter, rd_row, rd_col,
        output rd_letter, rd_score, row_curr, col_curr, q_I, q_Entry, q_Score, q_Done, done, win
    );
    modport master (
        output Start, Ack, target, letter_idx, letter_vld, del, enter, rd_row, rd_col,
        input  rd_letter, rd_score, row_curr, col_curr, q_I, q_Entry, q_Score, q_Done, done, win
    );
endinterface

// File: rtl/wordle_guess_scorer_score_unit.sv
// Six-cycle scorer: green pass, then one yellow search per position.
// scores shows the result including the current cycle's update, so the parent
// can commit it on the same edge that done is seen.
module wordle_score_unit
    import wordle_pkg::*;
(
    input  logic    Clk,
    input  logic    reset,
    input  logic    start,
    input  word_t   guess,
    input  word_t   target,
    output scores_t scores,
    output logic    done
);
    localparam int STAGES = WORD_LEN;

    logic [STAGES:0]     vld_pipe;
    scores_t             score_q, score_d;
    logic [WORD_LEN-1:0] used_q, used_d;
    logic                found;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            score_q  <= '0;
            used_q   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], start};
            score_q  <= score_d;
            used_q   <= used_d;
        end
    end

    always_comb begin
        score_d = score_q;
        used_d  = used_q;
        found   = 1'b0;
        if (vld_pipe[0]) begin
            for (int i = 0; i < WORD_LEN; i++) begin
                score_d[i] = (guess[i] == target[i]) ? SCORE_GREEN : SCORE_GRAY;
                used_d[i]  = (guess[i] == target[i]);
            end
        end
        // stage k searches on behalf of guess position k-1; lowest free match wins
        for (int k = 1; k <= STAGES; k++) begin
            if (vld_pipe[k] && score_q[k-1] != SCORE_GREEN) begin
                for (int j = 0; j < WORD_LEN; j++) begin
                    if (!found && !used_q[j] && target[j] == guess[k-1]) begin
                        found        = 1'b1;
                        score_d[k-1] = SCORE_YELLOW;
                        used_d[j]    = 1'b1;
                    end
                end
            end
        end
    end

    assign scores = score_d;
    assign done   = vld_pipe[STAGES];
endmodule

// File: rtl/wordle_guess_scorer.sv
// Guess entry FSM and letter/score grid; hands complete rows to the score
// unit and exposes the grid to the renderer through a combinational read port.
module wordle_guess_scorer #(
    parameter int NUM_ROWS = 6
) (
    input  logic Clk,
    input  logic reset,
    wordle_guess_scorer_if.slave bus
);
    import wordle_pkg::*;

    localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);
    localparam logic [2:0] FULL_COL = 3'(WORD_LEN);

    logic [3:0] state_q, state_d;
    logic [2:0] row_q, col_q;
    logic       win_q;
    word_t      target_q;
    word_t   [NUM_ROWS-1:0] grid_let;
    scores_t [NUM_ROWS-1:0] grid_sc;

    logic    sc_start, sc_done, row_full;
    scores_t sc_scores;

    assign row_full = (col_q == FULL_COL);
    assign sc_start = (state_q == QENTRY) && bus.enter && row_full;

    wordle_score_unit u_score (
        .Clk    (Clk),
        .reset  (reset),
        .start  (sc_start),
        .guess  (grid_let[row_q]),
        .target (target_q),
        .scores (sc_scores),
        .done   (sc_done)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state_q <= QI;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            QI:     if (bus.Start) state_d = QENTRY;
            QENTRY: if (sc_start)  state_d = QSCORE;
            QSCORE: if (sc_done)
                        state_d = (all_green(sc_scores) || row_q == LAST_ROW) ? QDONE : QENTRY;
            QDONE:  if (bus.Ack)   state_d = QI;
            default:               state_d = QI;
        endcase
    end

    always_comb begin
        bus.q_I      = (state_q == QI);
        bus.q_Entry  = (state_q == QENTRY);
        bus.q_Score  = (state_q == QSCORE);
        bus.q_Done   = (state_q == QDONE);
        bus.done     = (state_q == QDONE);
        bus.win      = win_q;
        bus.row_curr = row_q;
        bus.col_curr = col_q;
        bus.rd_letter = '0;
        bus.rd_score  = SCORE_NONE;
        if (bus.rd_row <= LAST_ROW && bus.rd_col < FULL_COL) begin
            bus.rd_letter = grid_let[bus.rd_row][bus.rd_col];
            bus.rd_score  = grid_sc[bus.rd_row][bus.rd_col];
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            row_q    <= '0;
            col_q    <= '0;
            win_q    <= 1'b0;
            target_q <= '0;
            grid_let <= '0;
            grid_sc  <= '0;
        end else begin
            case (state_q)
                QI: if (bus.Start) begin
                    target_q <= bus.target;
                    grid_let <= '0;
                    grid_sc  <= '0;
                    row_q    <= '0;
                    col_q    <= '0;
                    win_q    <= 1'b0;
                end
                // enter blocks del and letter in the same cycle, even when it is itself ignored
                QENTRY: if (bus.enter) begin
                end else if (bus.del) begin
                    if (col_q != 3'd0) begin
                        col_q <= col_q - 3'd1;
                        grid_let[row_q][col_q - 3'd1] <= '0;
                    end
                end else if (bus.letter_vld && !row_full && bus.letter_idx <= LETTER_MAX) begin
                    grid_let[row_q][col_q] <= bus.letter_idx;
                    col_q <= col_q + 3'd1;
                end
                QSCORE: if (sc_done) begin
                    grid_sc[row_q] <= sc_scores;
                    if (all_green(sc_scores)) begin
                        win_q <= 1'b1;
                    end else if (row_q != LAST_ROW) begin
                        row_q <= row_q + 3'd1;
                        col_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
